prefetch_unit: RTL and testbench
================================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter QUEUE_BYTES, default 16, queue capacity in bytes; multiple of 4, minimum 8.
REQ-002 Parameter RESET_ADDRESS, default 32'hFFFF_FFF0, linear fetch address after reset.
REQ-003 i_clock  input  1  sole clock, all state on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_flush  input  1  discard queue, restart fetch at i_flush_address.
REQ-006 i_flush_address  input  32  byte address of new instruction stream.
REQ-007 o_code_vaild  output  1  code fetch request to bus interface unit.
REQ-008 i_code_ready  input  1  one-cycle pulse; i_code_data_read valid in same cycle.
REQ-009 o_code_address  output  32  dword-aligned fetch address, low 2 bits always 0.
REQ-010 i_code_data_read  input  32  fetched dword, little-endian (byte k at address+k).
REQ-011 o_queue_data  output  32  next 4 queued bytes, oldest in [7:0].
REQ-012 o_queue_count  output  3  valid bytes in o_queue_data, 0..4.
REQ-013 i_queue_consume  input  3  bytes removed this cycle, must not exceed o_queue_count.
REQ-014 o_fetch_address  output  32  linear address of byte in o_queue_data[7:0].

Function
REQ-015 States: S_IDLE (no request), S_REQ (request outstanding, data kept), S_DISCARD (request outstanding, data dropped).
REQ-016 At most one outstanding request; o_code_vaild and o_code_address are registered and held stable from assertion until the i_code_ready cycle.
REQ-017 S_IDLE -> S_REQ when post-update free space >= 4 bytes; o_code_vaild rises the following cycle.
REQ-018 S_REQ, i_code_ready: write 4-skip bytes (byte skip.. 3) to the queue, clear skip, advance fetch pointer by 4; if space remains >= 4 after this cycle's write and consume, stay S_REQ with the new address, else S_IDLE with o_code_vaild low.
REQ-019 Written bytes are visible on o_queue_data/o_queue_count the cycle after i_code_ready.
REQ-020 Simultaneous write and consume in one cycle are both applied; count_next = count + written - consumed.
REQ-021 o_queue_count = min(count, 4); o_queue_data bytes at and above o_queue_count are don't-care.
REQ-022 o_fetch_address advances by i_queue_consume each cycle, modulo 2^32.
REQ-023 Fetch pointer wraps from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-024 i_flush (priority over consume and write): count <- 0, o_fetch_address <- i_flush_address, fetch pointer <- {i_flush_address[31:2],2'b00}, skip <- i_flush_address[1:0].
REQ-025 Flush in S_REQ without i_code_ready -> S_DISCARD; request and address held until i_code_ready, data dropped, then S_IDLE.
REQ-026 Flush coinciding with i_code_ready, or flush in S_DISCARD -> data dropped; next request uses latest flush target.
REQ-027 First request after flush from S_IDLE: o_code_vaild high the cycle after the flush cycle.
REQ-028 i_queue_consume > o_queue_count is a protocol violation flagged by assertion; behaviour undefined.

Reset
REQ-029 On i_reset: state S_IDLE, o_code_vaild 0, o_code_address 0, count 0, skip RESET_ADDRESS[1:0], fetch pointer RESET_ADDRESS & ~3, o_fetch_address RESET_ADDRESS.
REQ-030 Reset mid-request abandons the request; the next request issues after reset release, at RESET_ADDRESS & ~3.
REQ-031 First o_code_vaild rises one cycle after i_reset deasserts.

Structure
REQ-032 Package prefetch_pkg holds the state enum, default QUEUE_BYTES and RESET_ADDRESS.
REQ-033 Sub-module prefetch_byte_queue: byte-wide circular buffer, 0..4-byte write, 0..4-byte read per cycle, synchronous clear.

Verification
REQ-034 Reset release; ready 2 cycles later with 32'h44332211 -> o_code_address 32'hFFFF_FFF0, count 4, o_queue_data 32'h44332211, o_fetch_address 32'hFFFF_FFF0.
REQ-035 No consume, 4 readies -> count 4, o_code_vaild low after 4th ready; consume 4 -> request at base+16.
REQ-036 Flush 32'h0000_1003 in S_IDLE, data 32'hDDCCBBAA -> request 32'h0000_1000, count 1, byte0 8'hDD, o_fetch_address 32'h0000_1003, next request 32'h0000_1004.
REQ-037 Flush 32'h0000_2000 during request to 32'h0000_0100 -> address held until ready, data dropped, count 0, next request 32'h0000_2000.
REQ-038 Flush coincident with ready -> data dropped, next request at flush target; fetch at 32'hFFFF_FFFC -> next request 32'h0000_0000.

Source files
------------

// File: rtl/prefetch_pkg.sv
// Shared state encoding and default sizing for the instruction prefetch unit.
package prefetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_t;

    localparam int          QUEUE_BYTES_DEFAULT   = 16;
    localparam logic [31:0] RESET_ADDRESS_DEFAULT = 32'hFFFF_FFF0;

endpackage

// File: rtl/prefetch_byte_queue.sv
// Byte-wide circular buffer that accepts up to four bytes and releases up to
// four bytes per cycle; a synchronous clear empties it.
module prefetch_byte_queue
    import prefetch_pkg::*;
#(
    parameter int DEPTH = QUEUE_BYTES_DEFAULT
) (
    input  logic                       i_clock,
    input  logic                       i_clear,
    input  logic [2:0]                 i_write_count,
    input  logic [31:0]                i_write_data,
    input  logic [2:0]                 i_read_count,
    output logic [31:0]                o_read_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [PW:0]     DEPTH_W = (PW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Depth need not be a power of two, so pointer steps wrap explicitly.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input logic [2:0] step);
        logic [PW:0] sum;
        sum = {1'b0, ptr} + {{(PW-2){1'b0}}, step};
        if (sum >= DEPTH_W) sum = sum - DEPTH_W;
        return sum[PW-1:0];
    endfunction

    always_ff @(posedge i_clock) begin
        if (!i_clear) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < i_write_count)
                    mem[wrap_add(wr_ptr, 3'(i))] <= i_write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wrap_add(wr_ptr, i_write_count);
            rd_ptr <= wrap_add(rd_ptr, i_read_count);
            count  <= count + CW'(i_write_count) - CW'(i_read_count);
        end
    end

    always_comb begin
        o_read_data = '0;
        for (int i = 0; i < 4; i++)
            o_read_data[8*i +: 8] = mem[wrap_add(rd_ptr, 3'(i))];
    end

    assign o_count = count;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: issues dword code fetches ahead of the decoder and
// presents the next four queued bytes together with their linear address.
module prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int          QUEUE_BYTES   = QUEUE_BYTES_DEFAULT,
    parameter logic [31:0] RESET_ADDRESS = RESET_ADDRESS_DEFAULT
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic [31:0] i_flush_address,
    output logic        o_code_vaild,
    input  logic        i_code_ready,
    output logic [31:0] o_code_address,
    input  logic [31:0] i_code_data_read,
    output logic [31:0] o_queue_data,
    output logic [2:0]  o_queue_count,
    input  logic [2:0]  i_queue_consume,
    output logic [31:0] o_fetch_address
);
    localparam int            CW       = $clog2(QUEUE_BYTES + 1);
    localparam logic [CW-1:0] MAX_FILL = CW'(QUEUE_BYTES - 4);

    fetch_state_t  state;
    logic [31:0]   fetch_pointer;
    logic [31:0]   next_pointer;
    logic [1:0]    skip;
    logic [1:0]    next_skip;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          clear;
    logic          write_en;
    logic          space_ok;
    logic [2:0]    write_count;
    logic [2:0]    read_count;
    logic [31:0]   write_data;

    // A flush drops whatever arrives this cycle, so only undisturbed data is written.
    assign clear       = i_reset | i_flush;
    assign write_en    = (state == S_REQ) && i_code_ready && !clear;
    assign write_count = write_en ? 3'd4 - {1'b0, skip} : 3'd0;
    assign write_data  = i_code_data_read >> {skip, 3'b000};
    assign read_count  = clear ? 3'd0 : i_queue_consume;
    assign count_after = clear ? '0 : count + CW'(write_count) - CW'(read_count);
    assign space_ok    = count_after <= MAX_FILL;

    assign o_queue_count = (count > CW'(4)) ? 3'd4 : count[2:0];

    always_comb begin
        next_pointer = fetch_pointer;
        next_skip    = skip;
        if (i_flush) begin
            next_pointer = {i_flush_address[31:2], 2'b00};
            next_skip    = i_flush_address[1:0];
        end else if (write_en) begin
            next_pointer = fetch_pointer + 32'd4;
            next_skip    = 2'd0;
        end
    end

    prefetch_byte_queue #(
        .DEPTH (QUEUE_BYTES)
    ) u_queue (
        .i_clock       (i_clock),
        .i_clear       (clear),
        .i_write_count (write_count),
        .i_write_data  (write_data),
        .i_read_count  (read_count),
        .o_read_data   (o_queue_data),
        .o_count       (count)
    );

    // Request address stays frozen while outstanding, even across a flush.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state           <= S_IDLE;
            o_code_vaild    <= 1'b0;
            o_code_address  <= 32'd0;
            fetch_pointer   <= RESET_ADDRESS & ~32'd3;
            skip            <= RESET_ADDRESS[1:0];
            o_fetch_address <= RESET_ADDRESS;
        end else begin
            fetch_pointer   <= next_pointer;
            skip            <= next_skip;
            o_fetch_address <= i_flush ? i_flush_address
                                       : o_fetch_address + 32'(i_queue_consume);
            case (state)
                S_IDLE: begin
                    if (space_ok) begin
                        state          <= S_REQ;
                        o_code_vaild   <= 1'b1;
                        o_code_address <= next_pointer;
                    end
                end
                S_REQ: begin
                    if (i_code_ready) begin
                        if (space_ok) begin
                            o_code_address <= next_pointer;
                        end else begin
                            state        <= S_IDLE;
                            o_code_vaild <= 1'b0;
                        end
                    end else if (i_flush) begin
                        state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (i_code_ready) begin
                        state        <= S_IDLE;
                        o_code_vaild <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    o_code_vaild <= 1'b0;
                end
            endcase
        end
    end

    consume_within_count: assert property (
        @(posedge i_clock) disable iff (i_reset) i_queue_consume <= o_queue_count
    );

endmodule

// File: tb/tb_prefetch_unit.sv
// Scoreboard bench for prefetch_unit: directed fetch/flush/reset scenarios with
// expected request addresses and queue views checked by a negedge monitor.
module tb_prefetch_unit;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_flush;
    logic [31:0] i_flush_address;
    logic        o_code_vaild;
    logic        i_code_ready;
    logic [31:0] o_code_address;
    logic [31:0] i_code_data_read;
    logic [31:0] o_queue_data;
    logic [2:0]  o_queue_count;
    logic [2:0]  i_queue_consume;
    logic [31:0] o_fetch_address;

    typedef struct {
        string       name;
        logic        valid;
        logic        check_address;
        logic [31:0] address;
        logic [2:0]  count;
        logic [31:0] data;
        logic [31:0] fetch_address;
    } view_t;

    view_t       view_q[$];
    logic [31:0] addr_q[$];
    int          checks = 0;
    int          errors = 0;

    prefetch_unit dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_flush          (i_flush),
        .i_flush_address  (i_flush_address),
        .o_code_vaild     (o_code_vaild),
        .i_code_ready     (i_code_ready),
        .o_code_address   (o_code_address),
        .i_code_data_read (i_code_data_read),
        .o_queue_data     (o_queue_data),
        .o_queue_count    (o_queue_count),
        .i_queue_consume  (i_queue_consume),
        .o_fetch_address  (o_fetch_address)
    );

    always #5 i_clock = ~i_clock;

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: handshakes pop the expected request address, pending views pop a queue snapshot.
    always @(negedge i_clock) begin
        view_t       v;
        logic [31:0] mask;
        if (!i_reset && o_code_vaild && i_code_ready) begin
            if (addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL handshake: got request at %h expected none", o_code_address);
            end else begin
                compare("request address", o_code_address, addr_q.pop_front());
            end
        end
        if (view_q.size() != 0) begin
            v = view_q.pop_front();
            compare({v.name, ".valid"}, 32'(o_code_vaild), 32'(v.valid));
            if (v.check_address)
                compare({v.name, ".code_address"}, o_code_address, v.address);
            compare({v.name, ".count"}, 32'(o_queue_count), 32'(v.count));
            mask = '0;
            for (int i = 0; i < 4; i++)
                if (i < int'(v.count)) mask[8*i +: 8] = 8'hFF;
            if (v.count != 3'd0)
                compare({v.name, ".data"}, o_queue_data & mask, v.data & mask);
            compare({v.name, ".fetch_address"}, o_fetch_address, v.fetch_address);
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic valid, input logic check_address,
                               input logic [31:0] address, input logic [2:0] count,
                               input logic [31:0] data, input logic [31:0] fetch_address);
        view_t v;
        v.name          = name;
        v.valid         = valid;
        v.check_address = check_address;
        v.address       = address;
        v.count         = count;
        v.data          = data;
        v.fetch_address = fetch_address;
        view_q.push_back(v);
    endtask

    task automatic applyStimulus(input logic flush, input logic [31:0] flush_address, input logic [2:0] consume);
        i_flush         = flush;
        i_flush_address = flush_address;
        i_queue_consume = consume;
        tick();
        i_flush         = 1'b0;
        i_queue_consume = 3'd0;
    endtask

    task automatic serveRequest(input logic [31:0] data, input logic [2:0] consume, input logic flush,
                                input logic [31:0] flush_address, input logic [31:0] expected_address);
        int waited = 0;
        while (!o_code_vaild && waited < 20) begin
            tick();
            waited++;
        end
        if (!o_code_vaild) begin
            checks++;
            errors++;
            $display("[TB] FAIL request timeout: got valid %b expected 1 for %h", o_code_vaild, expected_address);
        end else begin
            addr_q.push_back(expected_address);
            i_code_ready     = 1'b1;
            i_code_data_read = data;
            i_flush          = flush;
            i_flush_address  = flush_address;
            i_queue_consume  = consume;
            tick();
            i_code_ready     = 1'b0;
            i_flush          = 1'b0;
            i_queue_consume  = 3'd0;
        end
    endtask

    initial begin
        i_reset          = 1'b1;
        i_flush          = 1'b0;
        i_flush_address  = 32'd0;
        i_code_ready     = 1'b0;
        i_code_data_read = 32'd0;
        i_queue_consume  = 3'd0;
        repeat (3) tick();

        $display("[TB] reset and first fills");
        checkOutput("reset", 1'b0, 1'b1, 32'd0, 3'd0, 32'd0, 32'hFFFF_FFF0);
        i_reset = 1'b0;
        tick();
        checkOutput("reset release", 1'b1, 1'b1, 32'hFFFF_FFF0, 3'd0, 32'd0, 32'hFFFF_FFF0);
        serveRequest(32'h4433_2211, 3'd0, 1'b0, 32'd0, 32'hFFFF_FFF0);
        checkOutput("first dword", 1'b1, 1'b1, 32'hFFFF_FFF4, 3'd4, 32'h4433_2211, 32'hFFFF_FFF0);
        serveRequest(32'h8877_6655, 3'd0, 1'b0, 32'd0, 32'hFFFF_FFF4);
        serveRequest(32'hCCBB_AA99, 3'd0, 1'b0, 32'd0, 32'hFFFF_FFF8);
        serveRequest(32'h00FF_EEDD, 3'd0, 1'b0, 32'd0, 32'hFFFF_FFFC);
        checkOutput("queue full", 1'b0, 1'b0, 32'd0, 3'd4, 32'h4433_2211, 32'hFFFF_FFF0);
        applyStimulus(1'b0, 32'd0, 3'd0);
        checkOutput("full holds", 1'b0, 1'b0, 32'd0, 3'd4, 32'h4433_2211, 32'hFFFF_FFF0);
        applyStimulus(1'b0, 32'd0, 3'd4);
        checkOutput("wrap request", 1'b1, 1'b1, 32'h0000_0000, 3'd4, 32'h8877_6655, 32'hFFFF_FFF4);
        serveRequest(32'h0403_0201, 3'd0, 1'b0, 32'd0, 32'h0000_0000);
        checkOutput("refilled", 1'b0, 1'b0, 32'd0, 3'd4, 32'h8877_6655, 32'hFFFF_FFF4);
        applyStimulus(1'b0, 32'd0, 3'd3);
        checkOutput("partial consume", 1'b0, 1'b0, 32'd0, 3'd4, 32'hBBAA_9988, 32'hFFFF_FFF7);
        applyStimulus(1'b0, 32'd0, 3'd1);
        checkOutput("space reopened", 1'b1, 1'b1, 32'h0000_0004, 3'd4, 32'hCCBB_AA99, 32'hFFFF_FFF8);

        $display("[TB] flush scenarios");
        serveRequest(32'hDEAD_BEEF, 3'd0, 1'b1, 32'h0000_0100, 32'h0000_0004);
        checkOutput("flush with ready", 1'b1, 1'b1, 32'h0000_0100, 3'd0, 32'd0, 32'h0000_0100);
        applyStimulus(1'b1, 32'h0000_2000, 3'd0);
        checkOutput("discard hold", 1'b1, 1'b1, 32'h0000_0100, 3'd0, 32'd0, 32'h0000_2000);
        applyStimulus(1'b0, 32'd0, 3'd0);
        checkOutput("discard hold later", 1'b1, 1'b1, 32'h0000_0100, 3'd0, 32'd0, 32'h0000_2000);
        serveRequest(32'h5555_5555, 3'd0, 1'b0, 32'd0, 32'h0000_0100);
        checkOutput("discard drop", 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 32'h0000_2000);
        applyStimulus(1'b0, 32'd0, 3'd0);
        checkOutput("request flush target", 1'b1, 1'b1, 32'h0000_2000, 3'd0, 32'd0, 32'h0000_2000);
        serveRequest(32'h0D0C_0B0A, 3'd0, 1'b0, 32'd0, 32'h0000_2000);
        checkOutput("fill after discard", 1'b1, 1'b1, 32'h0000_2004, 3'd4, 32'h0D0C_0B0A, 32'h0000_2000);
        serveRequest(32'h1312_1110, 3'd0, 1'b0, 32'd0, 32'h0000_2004);
        serveRequest(32'h1716_1514, 3'd0, 1'b0, 32'd0, 32'h0000_2008);
        serveRequest(32'h1B1A_1918, 3'd0, 1'b0, 32'd0, 32'h0000_200C);
        applyStimulus(1'b1, 32'h0000_1003, 3'd0);
        checkOutput("idle flush request", 1'b1, 1'b1, 32'h0000_1000, 3'd0, 32'd0, 32'h0000_1003);
        serveRequest(32'hDDCC_BBAA, 3'd0, 1'b0, 32'd0, 32'h0000_1000);
        checkOutput("unaligned flush", 1'b1, 1'b1, 32'h0000_1004, 3'd1, 32'h0000_00DD, 32'h0000_1003);
        serveRequest(32'h4433_2211, 3'd1, 1'b0, 32'd0, 32'h0000_1004);
        checkOutput("write and consume", 1'b1, 1'b1, 32'h0000_1008, 3'd4, 32'h4433_2211, 32'h0000_1004);
        applyStimulus(1'b1, 32'h0000_3000, 3'd0);
        applyStimulus(1'b1, 32'h0000_4002, 3'd0);
        checkOutput("double flush", 1'b1, 1'b1, 32'h0000_1008, 3'd0, 32'd0, 32'h0000_4002);
        serveRequest(32'hFFFF_FFFF, 3'd0, 1'b0, 32'd0, 32'h0000_1008);
        checkOutput("discard release", 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 32'h0000_4002);
        applyStimulus(1'b0, 32'd0, 3'd0);
        checkOutput("latest flush target", 1'b1, 1'b1, 32'h0000_4000, 3'd0, 32'd0, 32'h0000_4002);
        serveRequest(32'h1122_3344, 3'd0, 1'b0, 32'd0, 32'h0000_4000);
        checkOutput("skip two", 1'b1, 1'b1, 32'h0000_4004, 3'd2, 32'h0000_1122, 32'h0000_4002);

        $display("[TB] reset during request");
        i_reset = 1'b1;
        tick();
        checkOutput("reset mid request", 1'b0, 1'b1, 32'd0, 3'd0, 32'd0, 32'hFFFF_FFF0);
        i_reset = 1'b0;
        tick();
        checkOutput("restart after reset", 1'b1, 1'b1, 32'hFFFF_FFF0, 3'd0, 32'd0, 32'hFFFF_FFF0);
        tick();
        tick();

        compare("pending request expectations", 32'(addr_q.size()), 32'd0);
        compare("pending view expectations", 32'(view_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
